// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF/DM), memory and status signals around mem_port_arbiter.
// Signal suffixes follow the arbiter's view: slave = arbiter, master = surrounding pipeline/memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_done_o;

  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_done_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;

  logic          stall_if_o;
  logic          stall_mem_o;
  logic          err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output if_rdata_o, if_done_o, dm_rdata_o, dm_done_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output stall_if_o, stall_mem_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  if_rdata_o, if_done_o, dm_rdata_o, dm_done_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  stall_if_o, stall_mem_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and data memory (DM)
// with DM-first priority, IF anti-starvation, ack timeout and pipeline stall qualifiers.
//
// state   | meaning
// IDLE    | arbitrate pending requests
// BUSY_IF | IF read outstanding on the memory, waiting for ack
// BUSY_DM | DM load/store outstanding on the memory, waiting for ack
// RESP    | done pulse to the served port, no arbitration
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 255
) (
  input logic              clk_i,
  input logic              rst_ni,
  mem_port_arbiter_if.slave bus
);

  localparam int            SW      = $clog2(MAX_CONSEC + 1);
  localparam logic [SW-1:0] MAX_C   = SW'(MAX_CONSEC);
  localparam logic [7:0]    TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    to_q, to_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          if_done_q, if_done_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          dm_done_q, dm_done_d;
  logic          err_q, err_d;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    to_d        = to_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_done_d   = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    dm_done_d   = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        to_d = '0;
        if (bus.if_req_i && (starve_q == MAX_C || !bus.dm_req_i)) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr_i;
          mem_wdata_d = '0;
          starve_d    = '0;
        end else if (bus.dm_req_i) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
          // Count DM wins only while IF is actually waiting.
          if (bus.if_req_i) begin
            if (starve_q != MAX_C) starve_d = starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end
      end

      BUSY_IF, BUSY_DM: begin
        to_d = to_q + 8'd1;
        if (bus.mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (state_q == BUSY_IF) begin
            if_rdata_d = bus.mem_rdata_i;
            if_done_d  = 1'b1;
          end else begin
            dm_rdata_d = mem_we_q ? '0 : bus.mem_rdata_i;
            dm_done_d  = 1'b1;
          end
        end else if (to_q == TO_LAST) begin
          // Abort: the port still gets its done pulse so the pipeline never hangs.
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = RESP;
          if (state_q == BUSY_IF) begin
            if_rdata_d = '0;
            if_done_d  = 1'b1;
          end else begin
            dm_rdata_d = '0;
            dm_done_d  = 1'b1;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
        to_d    = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      to_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_rdata_q  <= '0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      to_q        <= to_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_done_q   <= if_done_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_done_q   <= dm_done_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.dm_done_o   = dm_done_q;
  assign bus.err_o       = err_q;
  assign bus.stall_if_o  = bus.if_req_i & ~if_done_q;
  assign bus.stall_mem_o = bus.dm_req_i & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: requesters, memory responder, reference memory,
// scoreboard queues checked on done pulses, and an arbitration-order model.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXC = 4;
  localparam int TMO  = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_CONSEC(MAXC), .TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Memory contents: mem_arr is the responder's storage, ref_arr the bench's expectation.
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_arr [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_arr.exists(a)) return ref_arr[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return init_val(a);
  endfunction

  logic [31:0] if_exp[$];
  logic [31:0] dm_exp[$];
  bit          grant_log[$];

  logic [31:0] cur_if_addr = '0;
  logic [31:0] cur_dm_addr = '0;
  logic [31:0] cur_dm_wdata = '0;
  logic        cur_dm_we = 1'b0;

  bit no_ack = 1'b0;
  int fixed_lat = -1;
  int lat = -1;
  int last_if_wait = 0;

  // IF addresses live below 0x100, DM addresses at 0x100 and above.
  function automatic bit addr_is_dm(input logic [31:0] a);
    return a >= 32'h100;
  endfunction

  // Memory responder
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.mem_ack_i   = 1'($urandom_range(0, 1));
        bus.mem_rdata_i = $urandom;
        lat = -1;
      end else if (bus.mem_ack_i) begin
        bus.mem_ack_i = 1'b0;
      end else if (bus.mem_req_o && !no_ack) begin
        if (lat < 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        if (lat == 0) begin
          if (addr_is_dm(bus.mem_addr_o)) begin
            chk("mem_addr_dm", bus.mem_addr_o, cur_dm_addr);
            chk1("mem_we_dm", bus.mem_we_o, cur_dm_we);
            if (cur_dm_we) chk("mem_wdata_dm", bus.mem_wdata_o, cur_dm_wdata);
          end else begin
            chk("mem_addr_if", bus.mem_addr_o, cur_if_addr);
            chk1("mem_we_if", bus.mem_we_o, 1'b0);
            chk("mem_wdata_if", bus.mem_wdata_o, 32'h0);
          end
          if (bus.mem_we_o) begin
            mem_arr[bus.mem_addr_o] = bus.mem_wdata_o;
            bus.mem_rdata_i = $urandom;
          end else begin
            bus.mem_rdata_i = mem_rd(bus.mem_addr_o);
          end
          bus.mem_ack_i = 1'b1;
          lat = -1;
        end else begin
          lat--;
        end
      end
    end
  end

  // Request levels as seen by the arbiter at each active edge
  logic snap_if = 1'b0;
  logic snap_dm = 1'b0;
  always @(posedge clk) begin
    snap_if <= bus.if_req_i;
    snap_dm <= bus.dm_req_i;
  end

  // Scoreboard monitor and arbitration-order model
  int   starve_m = 0;
  logic mreq_prev = 1'b0;
  int   run = 0;
  int   last_run = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.if_done_o) begin
          if (if_exp.size() == 0) fail_now("if_done without outstanding IF request");
          else chk("if_rdata", bus.if_rdata_o, if_exp.pop_front());
        end
        if (bus.dm_done_o) begin
          if (dm_exp.size() == 0) fail_now("dm_done without outstanding DM request");
          else chk("dm_rdata", bus.dm_rdata_o, dm_exp.pop_front());
        end
        if (bus.mem_req_o && !mreq_prev) begin
          bit exp_dm;
          bit got_dm;
          exp_dm = snap_dm && !(snap_if && starve_m == MAXC);
          got_dm = addr_is_dm(bus.mem_addr_o);
          chk1("grant_port", got_dm, exp_dm);
          grant_log.push_back(got_dm);
          if (exp_dm) starve_m = snap_if ? ((starve_m == MAXC) ? MAXC : starve_m + 1) : 0;
          else starve_m = 0;
        end
      end else begin
        starve_m = 0;
      end
      if (bus.mem_req_o) run++;
      else if (run > 0) begin
        last_run = run;
        run = 0;
      end
      mreq_prev = bus.mem_req_o;
    end
  end

  task automatic if_txn(input logic [31:0] addr, input bit keep);
    int n = 0;
    cur_if_addr = addr;
    if_exp.push_back(ref_rd(addr));
    bus.if_addr_i = addr;
    bus.if_req_i  = 1'b1;
    @(negedge clk);
    while (!bus.if_done_o && n < 600) begin
      chk1("stall_if_wait", bus.stall_if_o, 1'b1);
      n++;
      @(negedge clk);
    end
    last_if_wait = n;
    if (!bus.if_done_o) fail_now("if_done wait budget expired");
    else chk1("stall_if_done", bus.stall_if_o, 1'b0);
    if (!keep) bus.if_req_i = 1'b0;
  endtask

  task automatic dm_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit keep, input bit tmo);
    int n = 0;
    cur_dm_addr  = addr;
    cur_dm_we    = we;
    cur_dm_wdata = wdata;
    if (tmo || we) dm_exp.push_back(32'h0);
    else dm_exp.push_back(ref_rd(addr));
    if (we && !tmo) ref_arr[addr] = wdata;
    bus.dm_addr_i  = addr;
    bus.dm_we_i    = we;
    bus.dm_wdata_i = wdata;
    bus.dm_req_i   = 1'b1;
    @(negedge clk);
    while (!bus.dm_done_o && n < 600) begin
      chk1("stall_mem_wait", bus.stall_mem_o, 1'b1);
      n++;
      @(negedge clk);
    end
    if (!bus.dm_done_o) fail_now("dm_done wait budget expired");
    else chk1("stall_mem_done", bus.stall_mem_o, 1'b0);
    if (!keep) bus.dm_req_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_log [8];
    exp_log = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset with random inputs: every registered output must be zero
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.if_req_i   = 1'($urandom_range(0, 1));
      bus.if_addr_i  = $urandom;
      bus.dm_req_i   = 1'($urandom_range(0, 1));
      bus.dm_we_i    = 1'($urandom_range(0, 1));
      bus.dm_addr_i  = $urandom;
      bus.dm_wdata_i = $urandom;
      @(negedge clk);
    end
    chk1("rst_mem_req", bus.mem_req_o, 1'b0);
    chk1("rst_mem_we", bus.mem_we_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
    chk1("rst_if_done", bus.if_done_o, 1'b0);
    chk("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
    chk1("rst_dm_done", bus.dm_done_o, 1'b0);
    chk1("rst_err", bus.err_o, 1'b0);
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_addr_i  = '0;
    bus.dm_wdata_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("idle_mem_req", bus.mem_req_o, 1'b0);
    end

    // Single IF read, ack two cycles after mem_req rises
    mem_arr[32'h40] = 32'h8C220004;
    ref_arr[32'h40] = 32'h8C220004;
    fixed_lat = 2;
    if_txn(32'h40, 1'b0);
    chk("if_wait_lat2", 32'(last_if_wait), 32'd3);
    @(negedge clk);
    chk1("if_done_single_pulse", bus.if_done_o, 1'b0);
    chk("mem_req_len_lat2", 32'(last_run), 32'd3);
    repeat (3) @(negedge clk);
    chk("if_rdata_hold", bus.if_rdata_o, 32'h8C220004);

    // Earliest ack: done one cycle after the grant
    fixed_lat = 0;
    if_txn(32'h44, 1'b0);
    chk("if_wait_lat0", 32'(last_if_wait), 32'd1);
    @(negedge clk);
    chk("mem_req_len_lat0", 32'(last_run), 32'd1);
    fixed_lat = -1;

    // Simultaneous requests: DM store first, then IF
    grant_log.delete();
    fork
      if_txn(32'h80, 1'b0);
      dm_txn(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0);
    join
    chk("simul_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk1("simul_first_dm", grant_log[0], 1'b1);
      chk1("simul_second_if", grant_log[1], 1'b0);
    end
    dm_txn(1'b0, 32'h100, 32'h0, 1'b0, 1'b0);

    // Starvation: DM held continuously while IF waits
    repeat (2) @(negedge clk);
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 7; i++)
          dm_txn(1'b0, 32'h100 + 32'(4 * i), 32'h0, i < 6, 1'b0);
      end
      if_txn(32'h20, 1'b0);
    join
    chk("starve_grants", 32'(grant_log.size()), 32'd8);
    if (grant_log.size() == 8) begin
      for (int i = 0; i < 8; i++) chk1($sformatf("starve_seq_%0d", i), grant_log[i], exp_log[i]);
    end

    // Randomised concurrent traffic
    fork
      begin
        int gap;
        for (int i = 0; i < 40; i++) begin
          gap = int'($urandom_range(0, 3));
          if_txn($urandom_range(0, 63) << 2, (gap == 0) && (i < 39));
          repeat (gap) @(negedge clk);
        end
      end
      begin
        int gap;
        for (int k = 0; k < 40; k++) begin
          gap = int'($urandom_range(0, 3));
          dm_txn(1'($urandom_range(0, 1)), 32'h100 + ($urandom_range(0, 63) << 2), $urandom,
                 (gap == 0) && (k < 39), 1'b0);
          repeat (gap) @(negedge clk);
        end
      end
    join
    chk1("err_before_timeout", bus.err_o, 1'b0);

    // Timeout on a DM load
    repeat (2) @(negedge clk);
    no_ack = 1'b1;
    dm_txn(1'b0, 32'h180, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("timeout_mem_req_len", 32'(last_run), 32'(TMO));
    chk1("timeout_err_set", bus.err_o, 1'b1);
    no_ack = 1'b0;
    dm_txn(1'b1, 32'h184, 32'h12345678, 1'b0, 1'b0);
    dm_txn(1'b0, 32'h184, 32'h0, 1'b0, 1'b0);
    chk1("err_sticky", bus.err_o, 1'b1);

    // Reset in the middle of an IF transaction
    no_ack = 1'b1;
    cur_if_addr   = 32'h48;
    bus.if_addr_i = 32'h48;
    bus.if_req_i  = 1'b1;
    repeat (3) @(negedge clk);
    chk1("midrst_busy", bus.mem_req_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_mem_req_drop", bus.mem_req_o, 1'b0);
    chk1("midrst_no_done", bus.if_done_o, 1'b0);
    chk1("midrst_err_clear", bus.err_o, 1'b0);
    bus.if_req_i = 1'b0;
    no_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if_txn(32'h48, 1'b0);

    repeat (3) @(negedge clk);
    chk("if_queue_drained", 32'(if_exp.size()), 32'd0);
    chk("dm_queue_drained", 32'(dm_exp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
